// File: rtl/branch_verify_unit.sv
// EX-stage branch resolver: computes actual direction/target, compares with the
// IF/ID prediction, and drives a registered verify pulse toward the BPU.
module branch_verify_unit #(
  parameter int ENTRY_W = 64,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               correct_finish,
  input  logic               in_valid,
  input  logic [31:0]        in_pc,
  input  logic [2:0]         in_br_type,
  input  logic [2:0]         in_br_cond,
  input  logic               in_reg_target,
  input  logic [31:0]        in_imm_target,
  input  logic [31:0]        in_rs,
  input  logic [31:0]        in_rt,
  input  logic               in_pred_taken,
  input  logic [31:0]        in_pred_target,
  input  logic [ENTRY_W-1:0] in_entry,
  output logic               vr_ready,
  output logic [31:0]        vr_pc,
  output logic [2:0]         vr_br_type,
  output logic               vr_is_taken,
  output logic               vr_success,
  output logic [31:0]        vr_target,
  output logic [ENTRY_W-1:0] vr_entry,
  output logic               pending,
  output logic [CNT_W-1:0]   br_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_FIX = 1'b1;

  localparam logic [2:0] COND_EQ     = 3'd0;
  localparam logic [2:0] COND_NE     = 3'd1;
  localparam logic [2:0] COND_GEZ    = 3'd2;
  localparam logic [2:0] COND_GTZ    = 3'd3;
  localparam logic [2:0] COND_LEZ    = 3'd4;
  localparam logic [2:0] COND_LTZ    = 3'd5;
  localparam logic [2:0] COND_ALWAYS = 3'd6;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [0:0]  state;
  logic [0:0]  state_next;
  logic        accept;
  logic        taken;
  logic        rs_neg;
  logic        rs_zero;
  logic [31:0] act_target;
  logic [31:0] fall_through;
  logic        success;

  assign rs_neg  = in_rs[31];
  assign rs_zero = (in_rs == '0);

  always_comb begin
    taken = 1'b0;
    case (in_br_cond)
      COND_EQ:     taken = (in_rs == in_rt);
      COND_NE:     taken = (in_rs != in_rt);
      COND_GEZ:    taken = !rs_neg;
      COND_GTZ:    taken = !rs_neg && !rs_zero;
      COND_LEZ:    taken = rs_neg || rs_zero;
      COND_LTZ:    taken = rs_neg;
      COND_ALWAYS: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

  assign act_target   = in_reg_target ? in_rs : in_imm_target;
  assign fall_through = in_pc + 32'd8;
  assign success      = (taken == in_pred_taken) &&
                        (!taken || (act_target == in_pred_target));

  // Flush has priority over a same-cycle accept; WAIT_FIX drops everything.
  assign accept = in_valid && (in_br_type != 3'd0) && (state == IDLE) && !flush_i;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept && !success) state_next = WAIT_FIX;
      WAIT_FIX: if (correct_finish || flush_i) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign pending = (state == WAIT_FIX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vr_ready    <= 1'b0;
      vr_pc       <= '0;
      vr_br_type  <= '0;
      vr_is_taken <= 1'b0;
      vr_success  <= 1'b0;
      vr_target   <= '0;
      vr_entry    <= '0;
    end else begin
      vr_ready <= accept;
      if (accept) begin
        vr_pc       <= in_pc;
        vr_br_type  <= in_br_type;
        vr_is_taken <= taken;
        vr_success  <= success;
        vr_target   <= taken ? act_target : fall_through;
        vr_entry    <= in_entry;
      end
    end
  end

  // Counters follow the registered pulse, so they lag vr_ready by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (vr_ready) begin
      br_cnt <= br_cnt + CNT_ONE;
      if (!vr_success) miss_cnt <= miss_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_verify_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level reference model of the branch verifier.
module tb_branch_verify_unit;

  localparam int ENTRY_W = 64;
  localparam int CNT_W   = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic               flush_i;
  logic               correct_finish;
  logic               in_valid;
  logic [31:0]        in_pc;
  logic [2:0]         in_br_type;
  logic [2:0]         in_br_cond;
  logic               in_reg_target;
  logic [31:0]        in_imm_target;
  logic [31:0]        in_rs;
  logic [31:0]        in_rt;
  logic               in_pred_taken;
  logic [31:0]        in_pred_target;
  logic [ENTRY_W-1:0] in_entry;
  logic               vr_ready;
  logic [31:0]        vr_pc;
  logic [2:0]         vr_br_type;
  logic               vr_is_taken;
  logic               vr_success;
  logic [31:0]        vr_target;
  logic [ENTRY_W-1:0] vr_entry;
  logic               pending;
  logic [CNT_W-1:0]   br_cnt;
  logic [CNT_W-1:0]   miss_cnt;

  branch_verify_unit #(.ENTRY_W(ENTRY_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .correct_finish(correct_finish),
    .in_valid(in_valid), .in_pc(in_pc), .in_br_type(in_br_type),
    .in_br_cond(in_br_cond), .in_reg_target(in_reg_target),
    .in_imm_target(in_imm_target), .in_rs(in_rs), .in_rt(in_rt),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .in_entry(in_entry), .vr_ready(vr_ready), .vr_pc(vr_pc),
    .vr_br_type(vr_br_type), .vr_is_taken(vr_is_taken), .vr_success(vr_success),
    .vr_target(vr_target), .vr_entry(vr_entry), .pending(pending),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: last reported verify transaction, wrong-path flag, tallies.
  bit          m_pend;
  bit          m_ready;
  bit [31:0]   m_pc;
  bit [2:0]    m_type;
  bit          m_taken;
  bit          m_succ;
  bit [31:0]   m_target;
  bit [63:0]   m_entry;
  longint unsigned m_br;
  longint unsigned m_miss;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_taken(input bit [2:0] cond, input bit [31:0] rs, input bit [31:0] rt);
    int signed a;
    a = int'($signed(rs));
    case (cond)
      3'd0: return rs == rt;
      3'd1: return rs != rt;
      3'd2: return a >= 0;
      3'd3: return a > 0;
      3'd4: return a <= 0;
      3'd5: return a < 0;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_ready = 0; m_pc = 0; m_type = 0; m_taken = 0;
    m_succ = 0; m_target = 0; m_entry = 0; m_br = 0; m_miss = 0;
  endtask

  // Predict the effect of the upcoming clock edge from the present inputs.
  task automatic model_step();
    bit acc, t, s;
    bit [31:0] tgt;
    if (m_ready) begin
      m_br++;
      if (!m_succ) m_miss++;
    end
    acc = in_valid && in_br_type != 0 && !m_pend && !flush_i;
    t   = ref_taken(in_br_cond, in_rs, in_rt);
    tgt = in_reg_target ? in_rs : in_imm_target;
    s   = (t == in_pred_taken) && (!t || tgt == in_pred_target);
    if (m_pend) m_pend = !(correct_finish || flush_i);
    else        m_pend = acc && !s;
    m_ready = acc;
    if (acc) begin
      m_pc = in_pc; m_type = in_br_type; m_taken = t; m_succ = s;
      m_target = t ? tgt : in_pc + 32'd8;
      m_entry = in_entry;
    end
  endtask

  task automatic check_all();
    check("ready", vr_ready, m_ready);
    check("pending", pending, m_pend);
    check("br_cnt", br_cnt, m_br % (64'd1 << CNT_W));
    check("miss_cnt", miss_cnt, m_miss % (64'd1 << CNT_W));
    check("pc", vr_pc, m_pc);
    check("br_type", vr_br_type, m_type);
    check("is_taken", vr_is_taken, m_taken);
    check("success", vr_success, m_succ);
    check("target", vr_target, m_target);
    check("entry", vr_entry, m_entry);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic clear_in();
    flush_i = 0; correct_finish = 0; in_valid = 0; in_pc = 0; in_br_type = 0;
    in_br_cond = 0; in_reg_target = 0; in_imm_target = 0; in_rs = 0; in_rt = 0;
    in_pred_taken = 0; in_pred_target = 0; in_entry = 0;
  endtask

  task automatic set_br(input bit [2:0] typ, input bit [2:0] cond, input bit [31:0] pc,
                        input bit [31:0] rs, input bit [31:0] rt, input bit regt,
                        input bit [31:0] imm, input bit pt, input bit [31:0] ptgt);
    in_valid = 1; in_br_type = typ; in_br_cond = cond; in_pc = pc; in_rs = rs;
    in_rt = rt; in_reg_target = regt; in_imm_target = imm; in_pred_taken = pt;
    in_pred_target = ptgt; in_entry = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    reset = 0;
  endtask

  initial begin
    longint unsigned saved_br;
    clear_in();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("rst_pending", pending, 0);
    reset = 0;

    // 1: correctly predicted BEQ
    set_br(3'd1, 3'd0, 32'h1000, 32'd5, 32'd5, 0, 32'h1040, 1, 32'h1040);
    tick();
    check("t1_ready", vr_ready, 1);
    check("t1_success", vr_success, 1);
    check("t1_target", vr_target, 32'h1040);
    check("t1_pending", pending, 0);
    clear_in();
    tick();
    check("t1_pulse", vr_ready, 0);

    // 2: mispredicted BNE, wrong-path JR dropped, correct_finish releases
    set_br(3'd1, 3'd1, 32'h2000, 32'd3, 32'd3, 0, 32'h2040, 1, 32'h2040);
    tick();
    check("t2_success", vr_success, 0);
    check("t2_taken", vr_is_taken, 0);
    check("t2_target", vr_target, 32'h2008);
    check("t2_pending", pending, 1);
    set_br(3'd2, 3'd6, 32'h3000, 32'h1234, 32'd0, 1, 32'd0, 1, 32'h1234);
    tick();
    check("t2_drop", vr_ready, 0);
    clear_in();
    correct_finish = 1;
    tick();
    check("t2_release", pending, 0);
    clear_in();

    // 3: RET with wrong predicted target
    do_reset();
    set_br(3'd4, 3'd6, 32'h4000, 32'h8000_0100, 32'd0, 1, 32'd0, 1, 32'h8000_0200);
    tick();
    check("t3_success", vr_success, 0);
    check("t3_target", vr_target, 32'h8000_0100);
    check("t3_br0", br_cnt, 0);
    clear_in();
    correct_finish = 1;
    tick();
    check("t3_br1", br_cnt, 1);
    check("t3_miss1", miss_cnt, 1);
    clear_in();

    // 4: flush beats accept; flush releases WAIT_FIX
    saved_br = m_br;
    set_br(3'd1, 3'd3, 32'h5000, 32'd9, 32'd0, 0, 32'h5100, 1, 32'h5100);
    flush_i = 1;
    tick();
    check("t4_noready", vr_ready, 0);
    clear_in();
    tick();
    check("t4_br_frozen", br_cnt, saved_br);
    set_br(3'd1, 3'd3, 32'h5000, 32'd9, 32'd0, 0, 32'h5100, 0, 32'h0);
    tick();
    check("t4_pending", pending, 1);
    clear_in();
    flush_i = 1;
    tick();
    check("t4_flushed", pending, 0);
    clear_in();

    // 5: BLTZ on negative rs; fall-through wraps past 2^32
    set_br(3'd1, 3'd5, 32'h6000, 32'h8000_0000, 32'd0, 0, 32'h6100, 0, 32'h0);
    tick();
    check("t5_taken", vr_is_taken, 1);
    check("t5_success", vr_success, 0);
    clear_in();
    correct_finish = 1;
    tick();
    clear_in();
    set_br(3'd1, 3'd0, 32'hFFFF_FFFC, 32'd1, 32'd2, 0, 32'h100, 0, 32'h0);
    tick();
    check("t5_wrap", vr_target, 32'h0000_0004);
    clear_in();
    tick();

    // 6: async reset while waiting for a fix with br_cnt = 7
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_br(3'd1, 3'd6, 32'h7000 + 32'(i * 4), 0, 0, 0, 32'h7800, 1, 32'h7800);
      tick();
    end
    set_br(3'd1, 3'd6, 32'h7100, 0, 0, 0, 32'h7800, 0, 32'h0);
    tick();
    clear_in();
    tick();
    check("t6_br7", br_cnt, 7);
    check("t6_pend", pending, 1);
    #2;
    reset = 1;
    model_reset();
    #1;
    check("t6_pending0", pending, 0);
    check("t6_ready0", vr_ready, 0);
    check("t6_br0", br_cnt, 0);
    check("t6_miss0", miss_cnt, 0);
    @(posedge clk);
    #1;
    reset = 0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit [31:0] r, tgt;
      clear_in();
      r = $urandom;
      in_valid       = (r[3:0] != 0);
      in_br_type     = (r[5:4] == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      in_br_cond     = 3'($urandom_range(0, 6));
      in_pc          = $urandom;
      in_rs          = r[6] ? 32'($signed(4'($urandom))) : $urandom;
      in_rt          = r[7] ? in_rs : $urandom;
      in_reg_target  = r[8];
      in_imm_target  = $urandom;
      tgt            = in_reg_target ? in_rs : in_imm_target;
      in_pred_taken  = r[9];
      in_pred_target = r[10] ? $urandom : tgt;
      in_entry       = {$urandom, $urandom};
      flush_i        = (r[15:12] == 0);
      correct_finish = (r[17:16] == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
